// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, FSM states,
// ALU ops, mux selects and the packed control vector.
package ctrl_pkg;

  localparam logic [2:0] OpR3  = 3'b000;
  localparam logic [2:0] OpRi  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpSw  = 3'b011;
  localparam logic [2:0] OpJal = 3'b100;
  localparam logic [2:0] OpBeq = 3'b101;
  localparam logic [2:0] OpBne = 3'b110;
  localparam logic [2:0] OpLui = 3'b111;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StWbAlu  = 4'd4,
    StAddr   = 4'd5,
    StMemRd  = 4'd6,
    StWbMem  = 4'd7,
    StMemWr  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StLuiWb  = 4'd11
  } state_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBReg = 2'b00;
  localparam logic [1:0] SrcBInc = 2'b01;
  localparam logic [1:0] SrcBImm = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       link;
    logic       lui;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational state -> control-vector decode. Only DECODE, BRANCH and EXEC_R
// look at the instruction fields; FETCH gates its latches on memory ready.
module multicycle_output_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] opcode_i,
  input  logic [2:0] funct_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.alu_src_b = SrcBInc;
        ctrl_o.alu_op    = AluAdd;
        ctrl_o.pc_source = PcSrcAlu;
      end
      StDecode: begin
        // Branch target is computed here so BRANCH only has to compare.
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
        ctrl_o.branch    = (opcode_i == OpBeq) || (opcode_i == OpBne);
      end
      StExecR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBReg;
        ctrl_o.alu_op    = funct_i;
      end
      StExecI, StAddr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluAdd;
      end
      StWbAlu: ctrl_o.reg_write = 1'b1;
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StWbMem: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBReg;
        ctrl_o.alu_op        = AluSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PcSrcAluOut;
        ctrl_o.branch_ne     = (opcode_i == OpBne);
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSrcJump;
        ctrl_o.link      = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      StLuiWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.lui       = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit processor: state register, next-state
// dispatch and reset gating around the output decoder.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_INC = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [2:0] input_opcode,
  input  logic [2:0] input_funct,
  input  logic       input_mem_ready,
  output logic       output_pc_write,
  output logic       output_pc_write_cond,
  output logic       output_branch_ne,
  output logic [1:0] output_pc_source,
  output logic       output_iord,
  output logic       output_mem_read,
  output logic       output_mem_write,
  output logic       output_ir_write,
  output logic       output_reg_write,
  output logic       output_mem_to_reg,
  output logic       output_branch,
  output logic       output_link,
  output logic       output_lui,
  output logic       output_alu_src_a,
  output logic [1:0] output_alu_src_b,
  output logic [2:0] output_alu_op,
  output logic [3:0] output_state
);

  // The datapath owns the increment constant; a zero step would never advance the PC.
  if (PC_INC == 0) begin : g_bad_pc_inc
    $error("PC_INC must be non-zero");
  end

  state_e state_q, state_d;
  ctrl_t  ctrl_dec, ctrl;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (input_mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (input_opcode)
          OpR3:         state_d = StExecR;
          OpRi:         state_d = StExecI;
          OpLw, OpSw:   state_d = StAddr;
          OpJal:        state_d = StJump;
          OpBeq, OpBne: state_d = StBranch;
          OpLui:        state_d = StLuiWb;
          default:      state_d = StFetch;
        endcase
      end
      StExecR, StExecI: state_d = StWbAlu;
      StAddr:   state_d = (input_opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (input_mem_ready) state_d = StWbMem;
      StMemWr:  if (input_mem_ready) state_d = StFetch;
      StWbAlu, StWbMem, StBranch, StJump, StLuiWb: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  multicycle_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (input_opcode),
    .funct_i     (input_funct),
    .mem_ready_i (input_mem_ready),
    .ctrl_o      (ctrl_dec)
  );

  // Reset kills every enable immediately so an abandoned access never half-issues.
  always_comb begin
    ctrl         = Reset ? '0 : ctrl_dec;
    output_state = Reset ? StFetch : state_q;
  end

  assign output_pc_write      = ctrl.pc_write;
  assign output_pc_write_cond = ctrl.pc_write_cond;
  assign output_branch_ne     = ctrl.branch_ne;
  assign output_pc_source     = ctrl.pc_source;
  assign output_iord          = ctrl.iord;
  assign output_mem_read      = ctrl.mem_read;
  assign output_mem_write     = ctrl.mem_write;
  assign output_ir_write      = ctrl.ir_write;
  assign output_reg_write     = ctrl.reg_write;
  assign output_mem_to_reg    = ctrl.mem_to_reg;
  assign output_branch        = ctrl.branch;
  assign output_link          = ctrl.link;
  assign output_lui           = ctrl.lui;
  assign output_alu_src_a     = ctrl.alu_src_a;
  assign output_alu_src_b     = ctrl.alu_src_b;
  assign output_alu_op        = ctrl.alu_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each cycle's expected control
// vector is queued when inputs are driven and compared mid-cycle.
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [2:0] funct = 3'b000;
  logic       ready = 1'b0;

  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_write, mem_to_reg, branch, link, lui, alu_src_a;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [23:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.PC_INC(2)) dut (
    .CLK                  (clk),
    .Reset                (reset),
    .input_opcode         (opcode),
    .input_funct          (funct),
    .input_mem_ready      (ready),
    .output_pc_write      (pc_write),
    .output_pc_write_cond (pc_write_cond),
    .output_branch_ne     (branch_ne),
    .output_pc_source     (pc_source),
    .output_iord          (iord),
    .output_mem_read      (mem_read),
    .output_mem_write     (mem_write),
    .output_ir_write      (ir_write),
    .output_reg_write     (reg_write),
    .output_mem_to_reg    (mem_to_reg),
    .output_branch        (branch),
    .output_link          (link),
    .output_lui           (lui),
    .output_alu_src_a     (alu_src_a),
    .output_alu_src_b     (alu_src_b),
    .output_alu_op        (alu_op),
    .output_state         (state)
  );

  assign obs = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write,
                ir_write, reg_write, mem_to_reg, branch, link, lui, alu_src_a, alu_src_b,
                alu_op, state};

  // Expected outputs for one cycle, written from the per-state output table.
  function automatic logic [23:0] model(input state_e st, input logic [2:0] op,
                                        input logic [2:0] fn, input logic rdy,
                                        input logic rst);
    logic pw, pwc, bne, io, mr, mw, irw, rw, m2r, br, lk, lu, sa;
    logic [1:0] ps, sb;
    logic [2:0] ao;
    logic [3:0] sc;
    {pw, pwc, bne, io, mr, mw, irw, rw, m2r, br, lk, lu, sa} = '0;
    ps = 2'b00;
    sb = 2'b00;
    ao = 3'b000;
    sc = st;
    if (rst) begin
      sc = StFetch;
    end else begin
      case (st)
        StFetch:  begin mr = 1; irw = rdy; pw = rdy; sb = 2'b01; end
        StDecode: begin sb = 2'b10; br = (op == 3'b101 || op == 3'b110); end
        StExecR:  begin sa = 1; ao = fn; end
        StExecI:  begin sa = 1; sb = 2'b10; end
        StAddr:   begin sa = 1; sb = 2'b10; end
        StWbAlu:  rw = 1;
        StMemRd:  begin mr = 1; io = 1; end
        StWbMem:  begin rw = 1; m2r = 1; end
        StMemWr:  begin mw = 1; io = 1; end
        StBranch: begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; bne = (op == 3'b110); end
        StJump:   begin pw = 1; ps = 2'b10; lk = 1; rw = 1; end
        StLuiWb:  begin rw = 1; lu = 1; end
        default:  ;
      endcase
    end
    return {pw, pwc, bne, ps, io, mr, mw, irw, rw, m2r, br, lk, lu, sa, sb, ao, sc};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle's inputs just after the edge; compare on the falling edge.
  task automatic cycle(input string tag, input logic rst, input logic [2:0] op,
                       input logic [2:0] fn, input logic rdy, input state_e st);
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    funct  = fn;
    ready  = rdy;
    exp_q.push_back(model(st, op, fn, rdy, rst));
    tag_q.push_back(tag);
    @(negedge clk);
    check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  initial begin
    // Reset held two cycles with a ready memory and LW opcode: nothing may fire.
    cycle("rst0", 1, 3'b010, 3'b000, 1, StFetch);
    cycle("rst1", 1, 3'b010, 3'b000, 1, StFetch);

    // R3 funct 010
    cycle("r3_fetch",  0, 3'b000, 3'b010, 1, StFetch);
    cycle("r3_decode", 0, 3'b000, 3'b010, 0, StDecode);
    cycle("r3_exec",   0, 3'b000, 3'b010, 0, StExecR);
    cycle("r3_wb",     0, 3'b000, 3'b010, 1, StWbAlu);

    // LW with one fetch wait and two MEM_RD waits
    cycle("lw_fetch_wait", 0, 3'b010, 3'b000, 0, StFetch);
    cycle("lw_fetch",      0, 3'b010, 3'b000, 1, StFetch);
    cycle("lw_decode",     0, 3'b010, 3'b000, 1, StDecode);
    cycle("lw_addr",       0, 3'b010, 3'b000, 0, StAddr);
    cycle("lw_mem_wait0",  0, 3'b010, 3'b000, 0, StMemRd);
    cycle("lw_mem_wait1",  0, 3'b010, 3'b000, 0, StMemRd);
    cycle("lw_mem",        0, 3'b010, 3'b000, 1, StMemRd);
    cycle("lw_wb",         0, 3'b010, 3'b000, 0, StWbMem);

    // BNE then BEQ
    cycle("bne_fetch",  0, 3'b110, 3'b000, 1, StFetch);
    cycle("bne_decode", 0, 3'b110, 3'b000, 1, StDecode);
    cycle("bne_branch", 0, 3'b110, 3'b000, 0, StBranch);
    cycle("beq_fetch",  0, 3'b101, 3'b111, 1, StFetch);
    cycle("beq_decode", 0, 3'b101, 3'b111, 1, StDecode);
    cycle("beq_branch", 0, 3'b101, 3'b111, 1, StBranch);

    // JAL and LUI back-to-back
    cycle("jal_fetch",  0, 3'b100, 3'b000, 1, StFetch);
    cycle("jal_decode", 0, 3'b100, 3'b000, 1, StDecode);
    cycle("jal_jump",   0, 3'b100, 3'b000, 0, StJump);
    cycle("lui_fetch",  0, 3'b111, 3'b000, 1, StFetch);
    cycle("lui_decode", 0, 3'b111, 3'b000, 0, StDecode);
    cycle("lui_wb",     0, 3'b111, 3'b000, 1, StLuiWb);

    // RI: alu_op stays add regardless of funct
    cycle("ri_fetch",  0, 3'b001, 3'b110, 1, StFetch);
    cycle("ri_decode", 0, 3'b001, 3'b110, 1, StDecode);
    cycle("ri_exec",   0, 3'b001, 3'b110, 1, StExecI);
    cycle("ri_wb",     0, 3'b001, 3'b110, 1, StWbAlu);

    // SW stalled in MEM_WR, then reset mid-access
    cycle("sw_fetch",     0, 3'b011, 3'b000, 1, StFetch);
    cycle("sw_decode",    0, 3'b011, 3'b000, 1, StDecode);
    cycle("sw_addr",      0, 3'b011, 3'b000, 1, StAddr);
    cycle("sw_mem_wait0", 0, 3'b011, 3'b000, 0, StMemWr);
    cycle("sw_mem_wait1", 0, 3'b011, 3'b000, 0, StMemWr);
    cycle("sw_reset",     1, 3'b011, 3'b000, 0, StMemWr);
    cycle("post_reset",   0, 3'b011, 3'b000, 0, StFetch);

    // Complete SW with zero wait states, then back to FETCH
    cycle("sw2_fetch",  0, 3'b011, 3'b000, 1, StFetch);
    cycle("sw2_decode", 0, 3'b011, 3'b000, 1, StDecode);
    cycle("sw2_addr",   0, 3'b011, 3'b000, 1, StAddr);
    cycle("sw2_mem",    0, 3'b011, 3'b000, 1, StMemWr);
    cycle("sw2_done",   0, 3'b000, 3'b000, 0, StFetch);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
